// File: rtl/tick_debouncer_pkg.sv
// Shared button-debounce types: FSM state encoding and default timing constants.
// Reused by every button consumer in the design.
package tick_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_STABLE_TICKS = 4;
    localparam int unsigned DEF_LONG_TICKS   = 100;

    function automatic logic [15:0] sat_inc16(
        input logic [15:0] val,
        input logic [15:0] lim
    );
        return (val >= lim) ? lim : val + 16'd1;
    endfunction

endpackage

// File: rtl/tick_debouncer_sync.sv
// Generic 2-flop synchroniser for external pins; RST_VAL is the idle pin level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tick_debouncer.sv
// Tick-sampled push-button debouncer with press/release/long-press pulses.
// Long-press logic is built only when TICK_DEBOUNCER_LONG_PRESS_EN is defined.
module tick_debouncer
    import tick_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    if (STABLE_TICKS < 2 || STABLE_TICKS > 255) begin : g_bad_stable
        $error("tick_debouncer: STABLE_TICKS out of range 2..255");
    end
    if (LONG_TICKS <= STABLE_TICKS || LONG_TICKS > 65535) begin : g_bad_long
        $error("tick_debouncer: LONG_TICKS out of range");
    end

    localparam logic [7:0] STAB_LAST = 8'(STABLE_TICKS - 1);

    logic       sync_q;
    logic       act;
    btn_state_t state;
    logic [7:0] stab_cnt;
    logic       level_q;
    logic       press_q;
    logic       release_q;
    logic       rel_done;

    sync_2ff #(
        .RST_VAL(ACTIVE_LOW)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_raw),
        .q    (sync_q)
    );

    assign act      = sync_q ^ ACTIVE_LOW;
    assign rel_done = !act && (stab_cnt == STAB_LAST);

`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
    localparam logic [15:0] HOLD_MAX = 16'(LONG_TICKS);

    logic [15:0] hold_cnt;
    logic        long_q;
    logic        hold_hit;

    // True only on the increment that lands exactly on HOLD_MAX.
    assign hold_hit   = (hold_cnt == HOLD_MAX - 16'd1);
    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stab_cnt  <= 8'd0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
            hold_cnt  <= 16'd0;
            long_q    <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
            long_q    <= 1'b0;
`endif
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (act) begin
                            state    <= PRESS_WAIT;
                            stab_cnt <= 8'd1;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!act) begin
                            state    <= IDLE;
                            stab_cnt <= 8'd0;
                        end else if (stab_cnt == STAB_LAST) begin
                            state    <= PRESSED;
                            stab_cnt <= 8'd0;
                            level_q  <= 1'b1;
                            press_q  <= 1'b1;
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
                            hold_cnt <= 16'd0;
`endif
                        end else begin
                            stab_cnt <= stab_cnt + 8'd1;
                        end
                    end
                    PRESSED: begin
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
                        hold_cnt <= sat_inc16(hold_cnt, HOLD_MAX);
                        long_q   <= hold_hit;
`endif
                        if (!act) begin
                            state    <= RELEASE_WAIT;
                            stab_cnt <= 8'd1;
                        end
                    end
                    RELEASE_WAIT: begin
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
                        // A coinciding release wins so pulses stay exclusive.
                        hold_cnt <= sat_inc16(hold_cnt, HOLD_MAX);
                        long_q   <= hold_hit && !rel_done;
`endif
                        if (act) begin
                            state    <= PRESSED;
                            stab_cnt <= 8'd0;
                        end else if (rel_done) begin
                            state     <= IDLE;
                            stab_cnt  <= 8'd0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            stab_cnt <= stab_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_tick_debouncer.sv
// Self-checking bench for tick_debouncer: vector table, corner sequences,
// and random stimulus against a run-length reference model.
module tb_tick_debouncer;

    localparam int ST = 4;
    localparam int LT = 10;
    localparam bit AL = 1'b1;
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic tick;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    tick_debouncer #(
        .STABLE_TICKS(ST),
        .LONG_TICKS  (LT),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_p, cnt_r, cnt_l;

    // Reference: pin seen two clocks late; level flips after ST consecutive
    // opposite samples; long fires when ticks since press reach LT.
    bit m_q1, m_q2, m_level;
    int m_run, m_hold;
    bit e_p, e_r, e_l;

    typedef struct {
        bit pressed;
        int ticks;
        bit lvl;
        int np;
        int nr;
        int nl;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0b expected %0b at %0t",
                         name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q1 = AL;
        m_q2 = AL;
        m_level = 1'b0;
        m_run = 0;
        m_hold = 0;
        e_p = 1'b0;
        e_r = 1'b0;
        e_l = 1'b0;
    endtask

    task automatic model_step();
        bit a;
        bit hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        a = m_q2 ^ AL;
        m_q2 = m_q1;
        m_q1 = btn_raw;
        e_p = 1'b0;
        e_r = 1'b0;
        e_l = 1'b0;
        if (tick) begin
            hit = 1'b0;
            if (a != m_level) m_run++;
            else m_run = 0;
            if (m_level && m_hold < LT) begin
                m_hold++;
                hit = (m_hold == LT);
            end
            if (m_run == ST) begin
                m_level = a;
                m_run = 0;
                if (a) begin
                    e_p = 1'b1;
                    m_hold = 0;
                end else begin
                    e_r = 1'b1;
                end
            end
            e_l = LONG_EN && hit && !e_r;
        end
    endtask

    task automatic cycle(input bit raw, input bit tk);
        btn_raw = raw;
        tick = tk;
        @(posedge clk);
        model_step();
        #1;
        chk("btn_level", btn_level, m_level);
        chk("press_pulse", press_pulse, e_p);
        chk("release_pulse", release_pulse, e_r);
        chk("long_pulse", long_pulse, e_l);
        cnt_p += int'(press_pulse);
        cnt_r += int'(release_pulse);
        cnt_l += int'(long_pulse);
    endtask

    task automatic phase(input bit pressed, input int n);
        for (int t = 0; t < n; t++)
            for (int k = 0; k < 8; k++)
                cycle(pressed ^ AL, k == 7);
    endtask

    task automatic clear_counts();
        cnt_p = 0;
        cnt_r = 0;
        cnt_l = 0;
    endtask

    initial begin
        int first;
        bit r;
        int run_left;

        tbl[0]  = '{0, 3, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 1, 0, 0};
        tbl[3]  = '{1, 6, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0};
        tbl[5]  = '{1, 2, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 0, 0, 1};
        tbl[7]  = '{1, 5, 1, 0, 0, 0};
        tbl[8]  = '{0, 3, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 1, 0};
        tbl[10] = '{1, 2, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 0};
        tbl[12] = '{1, 3, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 1, 1, 0, 0};
        tbl[14] = '{0, 4, 0, 0, 1, 0};
        tbl[15] = '{1, 4, 1, 1, 0, 0};
        tbl[16] = '{1, 15, 1, 0, 0, 1};
        tbl[17] = '{0, 4, 0, 0, 1, 0};

        rst_n = 1'b0;
        btn_raw = AL;
        tick = 1'b0;
        model_reset();
        clear_counts();
        #1;
        chk("reset btn_level", btn_level, 1'b0);
        chk("reset press", press_pulse, 1'b0);
        repeat (3) cycle(AL, 1'b0);
        rst_n = 1'b1;
        repeat (4) cycle(AL, 1'b0);

        for (int i = 0; i < 18; i++) begin
            clear_counts();
            phase(tbl[i].pressed, tbl[i].ticks);
            chk($sformatf("vec%0d level", i), btn_level, tbl[i].lvl);
            chk_int($sformatf("vec%0d presses", i), cnt_p, tbl[i].np);
            chk_int($sformatf("vec%0d releases", i), cnt_r, tbl[i].nr);
            chk_int($sformatf("vec%0d longs", i), cnt_l,
                    LONG_EN ? tbl[i].nl : 0);
        end

        // Bounce: pin toggles every 10 clk for 50 clk, then settles pressed.
        clear_counts();
        for (int c = 0; c < 50; c++)
            cycle(((c / 10) % 2) != 0, (c % 8) == 7);
        chk_int("bounce presses", cnt_p, 0);
        clear_counts();
        for (int c = 50; c < 90; c++)
            cycle(1'b0, (c % 8) == 7);
        chk_int("settle presses", cnt_p, 1);
        chk("settle level", btn_level, 1'b1);
        clear_counts();
        phase(1'b0, 4);
        chk_int("bounce release", cnt_r, 1);

        // Continuous tick: 2 sync clocks + ST samples after the pin moves.
        repeat (3) cycle(AL, 1'b0);
        clear_counts();
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b1);
            if (press_pulse && first == 0) first = k;
        end
        chk_int("cont press latency", first, 6);
        chk_int("cont press count", cnt_p, 1);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b1);
            if (release_pulse && first == 0) first = k;
        end
        chk_int("cont release latency", first, 6);

        // Asynchronous reset while pressed.
        repeat (3) cycle(AL, 1'b0);
        phase(1'b1, 4);
        phase(1'b1, 2);
        chk("pre-reset level", btn_level, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async level", btn_level, 1'b0);
        chk("async press", press_pulse, 1'b0);
        chk("async release", release_pulse, 1'b0);
        chk("async long", long_pulse, 1'b0);
        clear_counts();
        repeat (2) cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        phase(1'b1, 4);
        chk_int("post-reset press", cnt_p, 1);
        chk_int("post-reset release", cnt_r, 0);
        chk("post-reset level", btn_level, 1'b1);
        phase(1'b0, 4);

        // Random runs of pin level and random tick spacing.
        r = 1'b1;
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                r = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 40);
            end
            run_left--;
            cycle(r, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
